// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run controller for the 4-digit BCD stopwatch counter.
// Debounces the start/pause button, runs the IDLE/RUN/PAUSE/DONE machine,
// generates the count tick and detects terminal count.
// Optional lap-hold display feature: define STOPWATCH_LAP_EN.

// Button conditioner: 2-FF synchroniser, debounce, rising-edge event.
module stopwatch_ctrl_db #(
  parameter int unsigned DB_CYCLES = 2000000
) (
  input  logic c_clk,
  input  logic R,
  input  logic raw,
  output logic evt
);

  localparam int unsigned CW = $clog2(DB_CYCLES + 1);

  logic          s1;
  logic          s2;
  logic          lvl;
  logic [CW-1:0] db_cnt;
  logic          accept;

  // The accepted level flips on the DB_CYCLES-th consecutive differing sample
  assign accept = (s2 != lvl) && (db_cnt == CW'(DB_CYCLES - 1));

  // Synchronise, count stable differing samples, emit a pulse on accepted 0->1
  always_ff @(posedge c_clk) begin
    if (R) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      lvl    <= 1'b0;
      db_cnt <= '0;
      evt    <= 1'b0;
    end else begin
      s1  <= raw;
      s2  <= s1;
      evt <= accept & s2;
      if (s2 == lvl) begin
        db_cnt <= '0;
      end else if (accept) begin
        lvl    <= s2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + CW'(1);
      end
    end
  end

endmodule

module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV  = 1000000,
  parameter int unsigned DB_CYCLES = 2000000
) (
  input  logic        c_clk,
  input  logic        R,
  input  logic        P,
  input  logic        L,
  input  logic [1:0]  sel,
  input  logic [7:0]  load,
  input  logic [15:0] cnt,
  output logic        cnt_clr,
  output logic [15:0] init_val,
  output logic        cnt_en,
  output logic        cnt_dir,
  output logic        done,
  output logic [1:0]  state_o,
  output logic [15:0] disp
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [1:0]    sel_q;
  logic [1:0]    sel_eff;
  logic          p_evt;
  logic          term;
  logic          tick;

  function automatic logic [3:0] clamp9(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  stopwatch_ctrl_db #(.DB_CYCLES(DB_CYCLES)) u_db_p (
    .c_clk (c_clk),
    .R     (R),
    .raw   (P),
    .evt   (p_evt)
  );

  assign cnt_clr = (state == IDLE);
  assign done    = (state == DONE);
  assign state_o = state;
  assign cnt_dir = ~sel_q[1];
  assign tick    = (presc == PW'(TICK_DIV - 1));
  assign term    = (state == RUN) && (cnt_dir ? (cnt == 16'h9999) : (cnt == 16'h0000));
  assign cnt_en  = (state == RUN) && tick && !term;

  // Start value: live mode select while idle, frozen copy once started
  always_comb begin
    sel_eff  = (state == IDLE) ? sel : sel_q;
    init_val = '0;
    unique case (sel_eff)
      2'b00:   init_val = 16'h0000;
      2'b10:   init_val = 16'h9999;
      default: init_val = {clamp9(load[7:4]), clamp9(load[3:0]), 8'h00};
    endcase
  end

  // Run state machine, tick prescaler and mode capture
  always_ff @(posedge c_clk) begin
    if (R) begin
      state <= IDLE;
      presc <= '0;
      sel_q <= 2'b00;
    end else begin
      unique case (state)
        IDLE: begin
          presc <= '0;
          sel_q <= sel;
          if (p_evt) state <= RUN;
        end
        RUN: begin
          presc <= tick ? '0 : presc + PW'(1);
          // terminal count has priority over a simultaneous pause request
          if (term)       state <= DONE;
          else if (p_evt) state <= PAUSE;
        end
        PAUSE: begin
          if (p_evt) state <= RUN;
        end
        DONE: begin
          state <= DONE;
        end
      endcase
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic        l_evt;
  logic        lap_hold;
  logic [15:0] lap_reg;

  stopwatch_ctrl_db #(.DB_CYCLES(DB_CYCLES)) u_db_l (
    .c_clk (c_clk),
    .R     (R),
    .raw   (L),
    .evt   (l_evt)
  );

  // Lap toggles only while running; reaching terminal count releases the hold
  always_ff @(posedge c_clk) begin
    if (R) begin
      lap_hold <= 1'b0;
      lap_reg  <= '0;
    end else if (state == RUN) begin
      if (term) begin
        lap_hold <= 1'b0;
      end else if (l_evt) begin
        lap_hold <= ~lap_hold;
        if (!lap_hold) lap_reg <= cnt;
      end
    end
  end

  assign disp = lap_hold ? lap_reg : cnt;
`else
  logic unused_l;
  assign unused_l = L;
  assign disp     = cnt;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Testbench for stopwatch_ctrl: vector table, directed corner sequences and
// randomized stimulus against a cycle-level behavioural model.
module tb_stopwatch_ctrl;

  localparam int TD = 4;
  localparam int DB = 3;
  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;
  localparam int S_DONE  = 3;

  logic        c_clk = 1'b0;
  logic        R, P, L;
  logic [1:0]  sel;
  logic [7:0]  load;
  logic [15:0] cnt;
  logic        cnt_clr, cnt_en, cnt_dir, done;
  logic [15:0] init_val, disp;
  logic [1:0]  state_o;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;
  int en_seen = 0;
  int en_at_max = 0;

  // model state
  int       m_state, m_val, m_runcyc, m_lapval;
  bit [1:0] m_selq;
  bit       m_hold;
  bit       m_s1 [2];
  bit       m_s2 [2];
  bit       m_lvl [2];
  bit       m_evt [2];
  bit       m_win [2][DB];

  stopwatch_ctrl #(.TICK_DIV(TD), .DB_CYCLES(DB)) dut (
    .c_clk    (c_clk),
    .R        (R),
    .P        (P),
    .L        (L),
    .sel      (sel),
    .load     (load),
    .cnt      (cnt),
    .cnt_clr  (cnt_clr),
    .init_val (init_val),
    .cnt_en   (cnt_en),
    .cnt_dir  (cnt_dir),
    .done     (done),
    .state_o  (state_o),
    .disp     (disp)
  );

  always #5 c_clk = ~c_clk;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[15:12] = 4'((v / 1000) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  function automatic int to_int(input logic [15:0] b);
    return int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  // BCD counter datapath driven by the controller outputs
  always @(posedge c_clk) begin
    if (R)            cnt <= '0;
    else if (cnt_clr) cnt <= init_val;
    else if (cnt_en)  cnt <= cnt_dir ? to_bcd((to_int(cnt) + 1) % 10000)
                                     : to_bcd((to_int(cnt) + 9999) % 10000);
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_init();
    bit [1:0] s;
    int hi, lo;
    s  = (m_state == S_IDLE) ? sel : m_selq;
    hi = (load[7:4] > 4'd9) ? 9 : int'(load[7:4]);
    lo = (load[3:0] > 4'd9) ? 9 : int'(load[3:0]);
    if (s == 2'b00)      return 0;
    else if (s == 2'b10) return 9999;
    else                 return hi * 1000 + lo * 100;
  endfunction

  task automatic model_edge(input int init_e, input bit en_e, input bit term_e, input bit dir_e);
    bit acc;
    bit raw;
    if (R) begin
      m_state = S_IDLE; m_val = 0; m_runcyc = 0; m_selq = 2'b00;
      m_hold = 1'b0; m_lapval = 0;
      for (int c = 0; c < 2; c++) begin
        m_s1[c] = 0; m_s2[c] = 0; m_lvl[c] = 0; m_evt[c] = 0;
        for (int k = 0; k < DB; k++) m_win[c][k] = 0;
      end
      return;
    end
    if (m_state == S_RUN) begin
      if (term_e) m_hold = 1'b0;
      else if (m_evt[1]) begin
        if (!m_hold) begin m_lapval = m_val; m_hold = 1'b1; end
        else m_hold = 1'b0;
      end
    end
    if (m_state == S_IDLE) m_val = init_e;
    else if (en_e)         m_val = dir_e ? (m_val + 1) % 10000 : (m_val + 9999) % 10000;
    if (m_state == S_IDLE)     m_runcyc = 0;
    else if (m_state == S_RUN) m_runcyc++;
    if (m_state == S_IDLE) m_selq = sel;
    case (m_state)
      S_IDLE:  if (m_evt[0]) m_state = S_RUN;
      S_RUN:   if (term_e) m_state = S_DONE; else if (m_evt[0]) m_state = S_PAUSE;
      S_PAUSE: if (m_evt[0]) m_state = S_RUN;
      default: m_state = S_DONE;
    endcase
    // a level is accepted once the last DB synchronised samples all differ from it
    for (int c = 0; c < 2; c++) begin
      raw = (c == 0) ? P : L;
      for (int k = DB - 1; k > 0; k--) m_win[c][k] = m_win[c][k-1];
      m_win[c][0] = m_s2[c];
      acc = 1'b1;
      for (int k = 0; k < DB; k++) if (m_win[c][k] == m_lvl[c]) acc = 1'b0;
      m_evt[c] = acc && !m_lvl[c];
      if (acc) m_lvl[c] = !m_lvl[c];
      m_s2[c] = m_s1[c];
      m_s1[c] = raw;
    end
  endtask

  // Called at a falling edge with inputs already driven; checks, then advances one cycle
  task automatic cycle();
    int init_e;
    bit dir_e, term_e, en_e;
    int disp_e;
    #1;
    init_e = model_init();
    dir_e  = !m_selq[1];
    term_e = (m_state == S_RUN) && (dir_e ? (m_val == 9999) : (m_val == 0));
    en_e   = (m_state == S_RUN) && (m_runcyc % TD == TD - 1) && !term_e;
`ifdef STOPWATCH_LAP_EN
    disp_e = m_hold ? m_lapval : m_val;
`else
    disp_e = m_val;
`endif
    if (chk_on) begin
      chk("state_o",  16'(state_o),  16'(m_state));
      chk("cnt_clr",  16'(cnt_clr),  16'(m_state == S_IDLE));
      chk("init_val", init_val,      to_bcd(init_e));
      chk("cnt_en",   16'(cnt_en),   16'(en_e));
      chk("cnt_dir",  16'(cnt_dir),  16'(dir_e));
      chk("done",     16'(done),     16'(m_state == S_DONE));
      chk("cnt",      cnt,           to_bcd(m_val));
      chk("disp",     disp,          to_bcd(disp_e));
    end
    if (cnt_en) en_seen++;
    if (cnt_en && cnt == 16'h9999) en_at_max++;
    model_edge(init_e, en_e, term_e, dir_e);
    @(posedge c_clk);
    @(negedge c_clk);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_state(input string name, input logic [1:0] s, input int lim);
    int n = 0;
    while (state_o != s && n < lim) begin cycle(); n++; end
    chk(name, 16'(state_o), 16'(s));
  endtask

  task automatic wait_cnt(input string name, input logic [15:0] v, input int lim);
    int n = 0;
    while (cnt != v && n < lim) begin cycle(); n++; end
    chk(name, cnt, v);
  endtask

  task automatic do_reset();
    R = 1'b1; P = 1'b0; L = 1'b0;
    cycles(2);
    R = 1'b0;
  endtask

  typedef struct {
    bit        r;
    bit [1:0]  sel;
    bit [7:0]  load;
    bit [1:0]  st;
    bit        clr;
    bit [15:0] init;
    bit        en;
    bit        dn;
  } vec_t;

  vec_t tv [8];

  initial begin
    int c0;
    tv[0] = '{1'b1, 2'b00, 8'h00, 2'b00, 1'b1, 16'h0000, 1'b0, 1'b0};
    tv[1] = '{1'b1, 2'b00, 8'h00, 2'b00, 1'b1, 16'h0000, 1'b0, 1'b0};
    tv[2] = '{1'b0, 2'b01, 8'h99, 2'b00, 1'b1, 16'h9900, 1'b0, 1'b0};
    tv[3] = '{1'b0, 2'b10, 8'h12, 2'b00, 1'b1, 16'h9999, 1'b0, 1'b0};
    tv[4] = '{1'b0, 2'b11, 8'h3A, 2'b00, 1'b1, 16'h3900, 1'b0, 1'b0};
    tv[5] = '{1'b0, 2'b01, 8'hF5, 2'b00, 1'b1, 16'h9500, 1'b0, 1'b0};
    tv[6] = '{1'b0, 2'b00, 8'h47, 2'b00, 1'b1, 16'h0000, 1'b0, 1'b0};
    tv[7] = '{1'b0, 2'b11, 8'hC0, 2'b00, 1'b1, 16'h9000, 1'b0, 1'b0};

    R = 1'b1; P = 1'b0; L = 1'b0; sel = 2'b00; load = 8'h00;
    @(negedge c_clk);

    // reset state and start-value decode
    for (int i = 0; i < 8; i++) begin
      R = tv[i].r; sel = tv[i].sel; load = tv[i].load;
      cycle();
      chk("tv_state",   16'(state_o),  16'(tv[i].st));
      chk("tv_cnt_clr", 16'(cnt_clr),  16'(tv[i].clr));
      chk("tv_init",    init_val,      tv[i].init);
      chk("tv_cnt_en",  16'(cnt_en),   16'(tv[i].en));
      chk("tv_done",    16'(done),     16'(tv[i].dn));
      chk_on = 1'b1;
    end

    // count up from zero
    sel = 2'b00; load = 8'h00;
    P = 1'b1;
    wait_state("start_run", 2'b01, 20);
    en_seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 4) P = 1'b0;
      cycle();
    end
    chk("up_cnt_12cyc", cnt, 16'h0003);
    chk("up_en_pulses", 16'(en_seen), 16'd3);

    // bouncing press pauses exactly once; pause freezes counting
    P = 1'b1; cycle();
    P = 1'b0; cycle();
    P = 1'b1;
    wait_state("bounce_pause", 2'b10, 20);
    cycles(6);
    chk("single_evt", 16'(state_o), 16'(2'b10));
    c0 = int'(cnt);
    en_seen = 0;
    P = 1'b0;
    cycles(8);
    chk("pause_no_en", 16'(en_seen), 16'd0);
    chk("pause_hold",  cnt, 16'(c0));
    P = 1'b1;
    wait_state("resume", 2'b01, 20);
    P = 1'b0;
    cycles(16);

    // up from loaded start to terminal count
    do_reset();
    sel = 2'b01; load = 8'h99;
    cycle();
    chk("load_init", init_val, 16'h9900);
    P = 1'b1;
    wait_state("load_run", 2'b01, 20);
    P = 1'b0;
    en_at_max = 0;
    wait_state("reach_done", 2'b11, 600);
    chk("done_flag", 16'(done), 16'd1);
    chk("done_cnt",  cnt, 16'h9999);
    cycles(8);
    chk("no_en_at_max", 16'(en_at_max), 16'd0);
    chk("done_stays",   cnt, 16'h9999);

    // down from 0000 terminates immediately; sel frozen afterwards
    do_reset();
    sel = 2'b11; load = 8'h00;
    cycles(2);
    P = 1'b1;
    wait_state("dn0_run", 2'b01, 20);
    en_seen = 0;
    cycle();
    chk("dn0_done",  16'(state_o), 16'(2'b11));
    chk("dn0_no_en", 16'(en_seen), 16'd0);
    P = 1'b0; sel = 2'b10;
    cycles(2);
    chk("sel_frozen_init", init_val, 16'h0000);
    chk("sel_frozen_dir",  16'(cnt_dir), 16'd0);

`ifdef STOPWATCH_LAP_EN
    // lap freeze, release, and release on terminal count
    do_reset();
    sel = 2'b00; load = 8'h00;
    P = 1'b1;
    wait_state("lap_run", 2'b01, 20);
    P = 1'b0;
    wait_cnt("lap_reach11", 16'h0011, 200);
    cycles(2);
    L = 1'b1;
    cycles(8);
    L = 1'b0;
    cycles(8);
    chk("lap_frozen",  disp, 16'h0012);
    chk("lap_counts",  cnt,  16'h0015);
    L = 1'b1;
    cycles(8);
    chk("lap_release", disp, cnt);
    L = 1'b0;
    cycles(6);
    do_reset();
    sel = 2'b01; load = 8'h99;
    P = 1'b1;
    wait_state("lap2_run", 2'b01, 20);
    P = 1'b0;
    wait_cnt("lap2_reach", 16'h9990, 500);
    L = 1'b1;
    cycles(8);
    L = 1'b0;
    wait_state("lap2_done", 2'b11, 100);
    chk("lap_done_release", disp, 16'h9999);
`endif

    // randomized stimulus against the model
    do_reset();
    begin
      int n = 0;
      while (n < 3000) begin
        int len;
        len  = $urandom_range(1, 8);
        P    = 1'($urandom_range(0, 1));
        L    = 1'($urandom_range(0, 1));
        sel  = 2'($urandom);
        load = {($urandom_range(0, 1) == 1) ? 4'h9 : 4'($urandom), 4'($urandom)};
        R    = ($urandom_range(0, 59) == 0) || (state_o == 2'b11 && $urandom_range(0, 3) == 0);
        for (int j = 0; j < len && n < 3000; j++) begin
          cycle();
          n++;
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
